// File: rtl/perf_pkg.sv
// perf_pkg -- shared definitions for the performance event counter.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, FROZEN=2, DONE=3)
//   STATE_W   : width of the state encoding / state_o debug port
//   sel_width : read-select width for a given channel count (never < 1)
package perf_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Select covers channels 0..num_ch-1 plus the cycle counter at num_ch.
  function automatic int sel_width(input int num_ch);
    return (num_ch + 1 <= 2) ? 1 : $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell -- one CNT_W-bit event counter with sticky overflow.
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   clr_i  : synchronous clear (same effect as reset)
//   inc_i  : add one this cycle
//   cnt_o  : current count
//   ovf_o  : sticky, set when an increment hits an all-ones count
// SATURATE=1 holds the count at all-ones on overflow; 0 wraps to zero.
module perf_counter_cell #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (inc_i) begin
      if (&cnt_reg) begin
        ovf_reg <= 1'b1;
        cnt_reg <= (SATURATE != 0) ? cnt_reg : '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_reg;
  assign ovf_o = ovf_reg;

endmodule

// File: rtl/perf_event_counter.sv
// perf_event_counter -- pipeline performance monitor.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   start_i / freeze_i : level controls (count enable / hold)
//   clear_i            : pulse; zero counters and overflow, go to IDLE
//   event_i            : per-channel event strobes, one count per high cycle
//   rd_req_i, rd_sel_i : read request; select NUM_CH = cycle counter
//   rd_valid_o, rd_data_o : registered read response (one cycle later)
//   overflow_o         : sticky overflow per counter, MSB = cycle counter
//   limit_reached_o    : high while in DONE
//   state_o            : FSM state for debug
// Optional feature macro PERF_SNAPSHOT_EN: adds snapshot_i which copies all
// counters into shadow registers; reads then return the shadow copies.
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int          SATURATE    = 0,
  parameter int unsigned CYCLE_LIMIT = 0,
  localparam int         SEL_W       = sel_width(NUM_CH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                freeze_i,
  input  logic                clear_i,
  input  logic [NUM_CH-1:0]   event_i,
`ifdef PERF_SNAPSHOT_EN
  input  logic                snapshot_i,
`endif
  input  logic                rd_req_i,
  input  logic [SEL_W-1:0]    rd_sel_i,
  output logic                rd_valid_o,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic [NUM_CH:0]     overflow_o,
  output logic                limit_reached_o,
  output logic [STATE_W-1:0]  state_o
);

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 4 || CNT_W > 64) begin : g_param_check
    $error("perf_event_counter: NUM_CH must be 1..16 and CNT_W 4..64");
  end

  state_e           state_reg, state_next;
  logic             count_en;
  logic             limit_hit;
  logic [CNT_W-1:0] cnt_w  [NUM_CH+1];
  logic [CNT_W-1:0] src_w  [NUM_CH+1];
  logic [NUM_CH:0]  ovf_w;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_valid_reg;
  logic [CNT_W-1:0] rd_data_reg;

  // Counting happens only from a registered RUN state; a clear drops the cycle.
  assign count_en = (state_reg == S_RUN) && !clear_i;

  // Cycle counter (index NUM_CH) becomes CYCLE_LIMIT at this edge.
  // One extra bit so an all-ones count cannot alias a small limit.
  assign limit_hit = (CYCLE_LIMIT != 0) &&
                     (({1'b0, cnt_w[NUM_CH]} + (CNT_W+1)'(1)) == (CNT_W+1)'(CYCLE_LIMIT));

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_CH; gi++) begin : g_cell
      logic inc;
      if (gi < NUM_CH) begin : g_ev
        assign inc = count_en && event_i[gi];
      end else begin : g_cyc
        assign inc = count_en;
      end
      perf_counter_cell #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
      ) u_cell (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .inc_i (inc),
        .cnt_o (cnt_w[gi]),
        .ovf_o (ovf_w[gi])
      );
    end
  endgenerate

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_reg [NUM_CH+1];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k <= NUM_CH; k++) shadow_reg[k] <= '0;
    end else if (snapshot_i) begin
      for (int k = 0; k <= NUM_CH; k++) shadow_reg[k] <= cnt_w[k];
    end
  end

  generate
    for (gi = 0; gi <= NUM_CH; gi++) begin : g_src
      assign src_w[gi] = shadow_reg[gi];
    end
  endgenerate
`else
  generate
    for (gi = 0; gi <= NUM_CH; gi++) begin : g_src
      assign src_w[gi] = cnt_w[gi];
    end
  endgenerate
`endif

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:   if (start_i) state_next = S_RUN;
        S_RUN: begin
          if (limit_hit)     state_next = S_DONE;
          else if (freeze_i) state_next = S_FROZEN;
          else if (!start_i) state_next = S_IDLE;
        end
        S_FROZEN: if (!freeze_i) state_next = start_i ? S_RUN : S_IDLE;
        default:  state_next = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Out-of-range selects read as zero but still produce a valid pulse.
  always_comb begin
    rd_mux = '0;
    if (int'(rd_sel_i) <= NUM_CH) rd_mux = src_w[rd_sel_i];
  end

  // Sampling before the edge gives the pre-update value of the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_req_i;
      if (rd_req_i) rd_data_reg <= rd_mux;
    end
  end

  assign rd_valid_o      = rd_valid_reg;
  assign rd_data_o       = rd_data_reg;
  assign overflow_o      = ovf_w;
  assign limit_reached_o = (state_reg == S_DONE);
  assign state_o         = state_reg;

endmodule

// File: tb/tb_perf_event_counter.sv
// tb_perf_event_counter -- randomized + directed bench for perf_event_counter.
// Four instances share one stimulus stream:
//   0: CNT_W=8 wrap, 1: CNT_W=4 saturate, 2: CNT_W=8 limit 100, 3: CNT_W=4 wrap.
// The reference keeps unbounded event totals and derives the visible counter
// value (wrap / saturate) and overflow flags from them arithmetically.
module tb_perf_event_counter;

  localparam int NI = 4;
  localparam int P_W   [NI] = '{8, 4, 8, 4};
  localparam int P_SAT [NI] = '{0, 1, 0, 0};
  localparam int P_LIM [NI] = '{0, 0, 100, 0};

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, freeze_i, clear_i, rd_req_i;
  logic [1:0] event_i;
  logic [1:0] rd_sel_i;

  logic       vld_o [NI];
  logic [2:0] ov_o  [NI];
  logic       lim_o [NI];
  logic [1:0] st_o  [NI];
  logic [7:0] d0, d2;
  logic [3:0] d1, d3;
  logic [63:0] dat_o [NI];

  assign dat_o[0] = 64'(d0);
  assign dat_o[1] = 64'(d1);
  assign dat_o[2] = 64'(d2);
  assign dat_o[3] = 64'(d3);

  always #5 clk_i = ~clk_i;

  perf_event_counter #(.NUM_CH(2), .CNT_W(8), .SATURATE(0), .CYCLE_LIMIT(0)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i),
    .clear_i(clear_i), .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_valid_o(vld_o[0]), .rd_data_o(d0), .overflow_o(ov_o[0]),
    .limit_reached_o(lim_o[0]), .state_o(st_o[0]));

  perf_event_counter #(.NUM_CH(2), .CNT_W(4), .SATURATE(1), .CYCLE_LIMIT(0)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i),
    .clear_i(clear_i), .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_valid_o(vld_o[1]), .rd_data_o(d1), .overflow_o(ov_o[1]),
    .limit_reached_o(lim_o[1]), .state_o(st_o[1]));

  perf_event_counter #(.NUM_CH(2), .CNT_W(8), .SATURATE(0), .CYCLE_LIMIT(100)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i),
    .clear_i(clear_i), .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_valid_o(vld_o[2]), .rd_data_o(d2), .overflow_o(ov_o[2]),
    .limit_reached_o(lim_o[2]), .state_o(st_o[2]));

  perf_event_counter #(.NUM_CH(2), .CNT_W(4), .SATURATE(0), .CYCLE_LIMIT(0)) u_d (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i),
    .clear_i(clear_i), .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_valid_o(vld_o[3]), .rd_data_o(d3), .overflow_o(ov_o[3]),
    .limit_reached_o(lim_o[3]), .state_o(st_o[3]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint tot    [NI][3];   // index 2 = cycle counter
  int     m_state[NI];
  bit     m_vld  [NI];
  longint m_data [NI];

  function automatic longint mval(int i, int ch);
    longint mx = (longint'(1) << P_W[i]) - 1;
    if (tot[i][ch] <= mx) return tot[i][ch];
    return (P_SAT[i] != 0) ? mx : tot[i][ch] % (mx + 1);
  endfunction

  function automatic logic [2:0] movf(int i);
    longint mx = (longint'(1) << P_W[i]) - 1;
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = (tot[i][c] > mx);
    return r;
  endfunction

  task automatic model_edge(input bit rs, st, fr, cl, input logic [1:0] ev,
                            input bit rq, input int sel);
    for (int i = 0; i < NI; i++) begin
      if (rs) begin
        m_state[i] = 0; m_vld[i] = 0; m_data[i] = 0;
        for (int c = 0; c < 3; c++) tot[i][c] = 0;
        continue;
      end
      m_vld[i] = rq;
      if (rq) m_data[i] = (sel <= 2) ? mval(i, sel) : 0;
      if (cl) begin
        for (int c = 0; c < 3; c++) tot[i][c] = 0;
        m_state[i] = 0;
        continue;
      end
      case (m_state[i])
        0: if (st) m_state[i] = 1;
        1: begin
          tot[i][2]++;
          for (int k = 0; k < 2; k++) if (ev[k]) tot[i][k]++;
          if (P_LIM[i] != 0 && tot[i][2] == P_LIM[i]) m_state[i] = 3;
          else if (fr)  m_state[i] = 2;
          else if (!st) m_state[i] = 0;
        end
        2: if (!fr) m_state[i] = st ? 1 : 0;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("state[%0d]", i), 64'(st_o[i]), 64'(m_state[i]));
      check_val($sformatf("ovf[%0d]", i), 64'(ov_o[i]), 64'(movf(i)));
      check_val($sformatf("limit[%0d]", i), 64'(lim_o[i]), 64'(m_state[i] == 3));
      check_val($sformatf("rd_valid[%0d]", i), 64'(vld_o[i]), 64'(m_vld[i]));
      check_val($sformatf("rd_data[%0d]", i), dat_o[i], 64'(m_data[i]));
    end
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge.
  task automatic step(input bit st, fr, cl, input logic [1:0] ev,
                      input bit rq, input int sel, input bit rs);
    start_i = st; freeze_i = fr; clear_i = cl; event_i = ev;
    rd_req_i = rq; rd_sel_i = 2'(sel); rst_i = rs;
    model_edge(rs, st, fr, cl, ev, rq, sel);
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic idle_read(input int sel);
    step(0, 0, 0, 2'b00, 1, sel, 0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_state[i] = 0; m_vld[i] = 0; m_data[i] = 0;
      for (int c = 0; c < 3; c++) tot[i][c] = 0;
    end

    // Reset
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    check_val("reset_state", 64'(st_o[0]), 64'd0);
    check_val("reset_rd_data", dat_o[0], 64'd0);
    check_val("reset_ovf", 64'(ov_o[0]), 64'd0);

    // Basic count: 10 RUN cycles, ch1 on alternate cycles, last one drops start
    step(1, 0, 0, 2'b00, 0, 0, 0);
    for (int j = 0; j < 10; j++)
      step(j < 9, 0, 0, {1'(j % 2 == 0), 1'b1}, 0, 0, 0);
    check_val("basic_state_idle", 64'(st_o[0]), 64'd0);
    idle_read(0); check_val("basic_ch0", dat_o[0], 64'd10);
    idle_read(1); check_val("basic_ch1", dat_o[0], 64'd5);
    idle_read(2); check_val("basic_cycle", dat_o[0], 64'd10);
    idle_read(3); check_val("sel_oob_data", dat_o[0], 64'd0);
    check_val("sel_oob_valid", 64'(vld_o[0]), 64'd1);

    // Overflow: 17 events on 4-bit counters (wrap vs saturate)
    step(0, 0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    for (int j = 0; j < 17; j++) step(j < 16, 0, 0, 2'b01, 0, 0, 0);
    idle_read(0);
    check_val("wrap_ch0", dat_o[3], 64'd1);
    check_val("wrap_ovf0", 64'(ov_o[3][0]), 64'd1);
    check_val("sat_ch0", dat_o[1], 64'd15);
    check_val("sat_ovf0", 64'(ov_o[1][0]), 64'd1);

    // Freeze window
    step(0, 0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    for (int j = 0; j < 4; j++) step(1, j == 3, 0, 2'b11, 0, 0, 0);
    for (int j = 0; j < 3; j++) step(1, 1, 0, 2'b11, 1, j == 2 ? 2 : 0, 0);
    check_val("freeze_hold_ch0", dat_o[0], 64'd4);
    step(1, 0, 0, 2'b11, 1, 2, 0);
    check_val("freeze_cycle", dat_o[0], 64'd4);
    // Read on the same edge as an event returns the pre-increment value
    step(1, 0, 0, 2'b11, 1, 0, 0);
    check_val("same_edge_read", dat_o[0], 64'd4);
    step(1, 0, 0, 2'b11, 1, 0, 0);
    check_val("resume_count", dat_o[0], 64'd5);

    // Cycle limit of 100 on instance 2
    step(0, 0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    for (int j = 0; j < 110; j++) begin
      step(1, 0, 0, 2'b11, 0, 0, 0);
      if (j == 98) check_val("limit_before", 64'(lim_o[2]), 64'd0);
      if (j == 99) check_val("limit_at_100", 64'(lim_o[2]), 64'd1);
    end
    step(1, 0, 0, 2'b11, 1, 0, 0); check_val("limit_ch0", dat_o[2], 64'd100);
    step(1, 0, 0, 2'b11, 1, 2, 0); check_val("limit_cycle", dat_o[2], 64'd100);
    step(1, 0, 1, 2'b11, 0, 0, 0);
    check_val("limit_clear_state", 64'(st_o[2]), 64'd0);
    check_val("limit_clear_flag", 64'(lim_o[2]), 64'd0);
    idle_read(2); check_val("limit_clear_cnt", dat_o[2], 64'd0);

    // Reset mid-RUN together with clear and a read
    step(1, 0, 0, 2'b11, 0, 0, 0);
    step(1, 0, 0, 2'b11, 1, 0, 0);
    step(1, 0, 1, 2'b11, 1, 2, 1);
    check_val("rst_mid_state", 64'(st_o[0]), 64'd0);
    check_val("rst_mid_valid", 64'(vld_o[0]), 64'd0);
    check_val("rst_mid_data", dat_o[0], 64'd0);

    // Randomized phase
    for (int j = 0; j < 600; j++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 47) == 0, 2'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_event_counter.md
Name: perf_event_counter

Overview:
Parametrised hardware performance-monitor block for the pipelined CPU. Counts per-cycle pipeline events (stall, flush, branch, retired instruction, ...) on NUM_CH channels plus a free-running cycle counter. Supports run/freeze/clear control, an optional auto-stop cycle limit, and a registered read port. Sits beside the CPU top and taps hazard/control strobes, so stall and flush statistics come from hardware rather than from bench-side probing.

Parameters:
NUM_CH, 4, number of event channels (1..16)
CNT_W, 32, width of every counter including the cycle counter (4..64)
SATURATE, 0, 1 = counters stick at all-ones; 0 = counters wrap to 0
CYCLE_LIMIT, 0, auto-stop after this many RUN cycles; 0 = no limit

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  level; 1 = counting enabled
freeze_i  in  1  level; 1 = hold all counters
clear_i  in  1  pulse; zero counters and flags, return to IDLE
event_i  in  NUM_CH  per-channel event strobe, one count per cycle high
rd_req_i  in  1  read request pulse
rd_sel_i  in  $clog2(NUM_CH+1)  0..NUM_CH-1 = channel, NUM_CH = cycle counter
rd_valid_o  out  1  read data valid, one-cycle pulse
rd_data_o  out  CNT_W  read data
overflow_o  out  NUM_CH+1  sticky per-counter overflow; bit NUM_CH = cycle counter
limit_reached_o  out  1  high while in DONE
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (rst_i high at edge): state IDLE, all counters 0, overflow_o 0, rd_valid_o 0, rd_data_o 0, limit_reached_o 0. rst_i overrides every other input.
- FSM states: IDLE=0, RUN=1, FROZEN=2, DONE=3.
  - IDLE: start_i=1 -> RUN.
  - RUN: clear_i -> IDLE; else CYCLE_LIMIT!=0 and cycle counter reaches CYCLE_LIMIT at this edge -> DONE; else freeze_i -> FROZEN; else start_i=0 -> IDLE.
  - FROZEN: freeze_i=0 -> RUN if start_i, else IDLE.
  - DONE: exits only on clear_i or rst_i (-> IDLE).
- Counting: only on edges where the registered state is RUN and clear_i=0. Cycle counter +1; channel k +1 if event_i[k]. New value visible the cycle after the edge.
- The RUN->FROZEN/IDLE edge still counts that cycle. The first cycle in RUN after leaving IDLE is counted. The final cycle that reaches CYCLE_LIMIT is counted. Nothing is counted in IDLE, FROZEN or DONE.
- Overflow: increment at all-ones sets the matching overflow_o bit (sticky). Counter becomes 0 when SATURATE=0, stays all-ones when SATURATE=1.
- clear_i in any state: all counters and overflow_o go to 0, state goes to IDLE, and events in that cycle are dropped. clear_i has priority over start_i, freeze_i and the limit.
- Read: rd_req_i at edge N -> rd_valid_o=1 and rd_data_o = selected counter value before edge N's update, both during cycle N+1. rd_sel_i > NUM_CH returns 0 and still pulses valid. Back-to-back requests are accepted every cycle. rd_data_o holds its value when valid is low.
- Widths: $clog2(NUM_CH+1) select is required to be at least 1 bit; parameter check errors out if NUM_CH=0 or CNT_W<4.

Optional Feature:
PERF_SNAPSHOT_EN
- Defined: adds input snapshot_i. On a snapshot_i edge, all NUM_CH+1 counters are copied atomically into shadow registers, with the same pre-update semantics as reads. Reads return shadow values. clear_i and rst_i also zero the shadows.
- Undefined: no snapshot_i port, no shadow registers, reads return live counters.

Decomposition:
- Shared package perf_pkg: state enum (IDLE/RUN/FROZEN/DONE), state width constant, and a function computing the select width.
- One sub-module perf_counter_cell: CNT_W counter with inc, clr, SATURATE mode and sticky overflow. Instantiated NUM_CH+1 times by generate.
- The FSM and read mux live in the top.

Test Plan:
- NUM_CH=2, CNT_W=8: start_i=1, event_i[0] high 10 cycles, event_i[1] on alternate cycles, then start_i=0 -> ch0=10, ch1=5, cycle=10, state IDLE.
- CNT_W=4, SATURATE=0, 17 events -> ch0=1, overflow_o[0]=1. Repeat with SATURATE=1 -> ch0=15, overflow_o[0]=1.
- Run 4 cycles with events, freeze_i=1 for 3 cycles with events high, release -> counts frozen at 4 during freeze, then increment again; cycle=4 after the freeze window.
- CYCLE_LIMIT=100, events always high -> limit_reached_o rises after exactly 100 RUN cycles; all counters=100 and remain so. clear_i -> IDLE, all 0, limit_reached_o=0.
- rd_req_i with rd_sel_i=2 (NUM_CH=2) -> cycle count next cycle. rd_sel_i=3 -> rd_data_o=0 with rd_valid_o=1. A read on the same edge as an event returns the pre-increment value.
- rst_i asserted mid-RUN together with clear_i and rd_req_i -> all outputs 0 next cycle, state IDLE, no rd_valid_o pulse.
